spi_byte_scheduler: RTL and testbench
=====================================

# spi_byte_scheduler

Arbitrates and sequences byte transfers from two requesters onto the single SPI byte engine that drives the display Pmod. Requester 0 is the display init/command path and requester 1 the frame/text refresh path. The block owns the engine's SPI_EN/SPI_DATA/SPI_FIN handshake. It drives the display D/C line stable for the whole byte, holds the engine for a requester's multi-byte burst until that requester's LAST byte, and flags an engine that never finishes.

## Interface
- TIMEOUT_CYCLES, 1024: cycles allowed in WAIT_FIN before abort; must be ≥ 300; counter width is clog2(TIMEOUT_CYCLES+1).
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- R0_REQ / R1_REQ  in  1  requester has a byte pending.
- R0_DATA / R1_DATA  in  8  byte to send, MSB first on the wire.
- R0_DC / R1_DC  in  1  D/C level for this byte: 0 = command, 1 = data.
- R0_LAST / R1_LAST  in  1  byte ends the requester's burst.
- R0_ACK / R1_ACK  out  1  one-cycle pulse: byte fully shifted out.
- SPI_EN  out  1  to engine; start and hold a transfer.
- SPI_DATA  out  8  to engine; registered byte.
- SPI_FIN  in  1  from engine; high while the engine is in its done state.
- DC  out  1  registered D/C to the display pin.
- BUSY  out  1  high in any state other than IDLE.
- OWNER  out  1  index of the current or most recent grantee.
- TIMEOUT_ERR  out  1  sticky; cleared only by RST.

## Operation
- States: IDLE, LOAD, WAIT_FIN, RELEASE.
- IDLE:
  - If a lock is held and the lock owner's REQ=1, grant the owner.
  - Otherwise, if any REQ=1, grant by round-robin. The requester that is not OWNER wins a tie.
  - On grant: register DATA into SPI_DATA, DC into DC, and LAST into last_q. Set OWNER. Go to LOAD.
- LOAD: assert SPI_EN (SPI_DATA is already valid this cycle, because the engine captures data while idle). Go to WAIT_FIN.
- WAIT_FIN:
  - Hold SPI_EN=1 and keep SPI_DATA/DC frozen. Increment the timeout counter.
  - On SPI_FIN=1: pulse the owner's ACK, drop SPI_EN, go to RELEASE.
  - If last_q=1, clear the lock; otherwise set the lock to the owner.
- RELEASE: SPI_EN=0. Wait for SPI_FIN=0, then go to IDLE. SPI_EN is never re-asserted while SPI_FIN=1.
- Timeout: the counter reaches TIMEOUT_CYCLES in WAIT_FIN without SPI_FIN.
  - Drop SPI_EN, set TIMEOUT_ERR, clear the lock, go to RELEASE.
  - No ACK is issued; the requester re-presents the byte.
- Lock release without LAST: if the lock owner has REQ=0 while in IDLE, clear the lock and arbitrate normally in the same cycle.
- Requesters hold DATA/DC/LAST stable from raising REQ until their ACK. After ACK they may present the next byte in the following cycle.
- A REQ withdrawn after grant is ignored: the transfer completes and ACK still pulses.
- SPI_FIN=1 seen in IDLE or LOAD is ignored.

## Timing
- Reset values: SPI_EN=0, SPI_DATA=8'h00, DC=0, ACKs=0, BUSY=0, OWNER=1 (so R0 wins the first tie), TIMEOUT_ERR=0, lock clear, state IDLE.
- RST mid-transfer drops SPI_EN in the next cycle. The engine returns to idle through its own done/idle path.
- REQ sampled high in IDLE at cycle n gives LOAD at n+1 and SPI_EN=1 from n+1. The SPI_FIN=1 cycle gives ACK in that same cycle and SPI_EN=0 in the next.
- With the engine's fixed cost of about 262 cycles per byte, one byte takes engine time plus 3 overhead cycles.
- ACKs are never high together; at most one ACK per byte.

## Structure
- Shared package: state encoding localparams (IDLE=2'd0, LOAD=2'd1, WAIT_FIN=2'd2, RELEASE=2'd3) and the requester index constants, reused by later display-path blocks.
- One natural sub-module: rr_arbiter2 (combinational two-way round-robin with lock input, priority pointer registered in the parent).
- The SPI byte engine is instantiated beside this block at display top level, not inside it.

## Test plan
- Single byte: R0 sends 8'hAE with DC=0, LAST=1 → SPI_EN rises the cycle after REQ, SPI_DATA=8'hAE, DC=0, exactly one R0_ACK on SPI_FIN, SPI_EN low next cycle, BUSY low after FIN falls.
- Tie after reset: R0 and R1 request together (8'h81, 8'h55) → R0 granted first, then R1. OWNER goes 0 then 1.
- Burst lock: R1 sends 3 bytes (LAST on the 3rd) while R0 requests from byte 1 → all three R1 ACKs occur before any R0 grant; R0 is granted next.
- Lock drop: R0 sends byte 1 with LAST=0, then drops REQ while R1 is pending → R1 is granted on the next IDLE cycle.
- Timeout: TIMEOUT_CYCLES=400 and SPI_FIN held 0 → SPI_EN drops after 400 WAIT_FIN cycles, TIMEOUT_ERR=1 and stays high, no ACK, next REQ is still served.
- Reset mid-transfer: assert RST during WAIT_FIN → SPI_EN=0, OWNER=1, TIMEOUT_ERR=0 next cycle. After RST, a new byte completes normally.

Source files
------------

// File: rtl/spi_byte_scheduler_pkg.sv
// spi_byte_scheduler_pkg: shared state encoding and requester indices for the display SPI path
//   No ports. Imported by the scheduler, its arbiter and later display-path blocks.
package spi_byte_scheduler_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t LOAD     = 2'd1;
    localparam state_t WAIT_FIN = 2'd2;
    localparam state_t RELEASE  = 2'd3;
    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;
endpackage

// File: rtl/spi_byte_scheduler_if.sv
// spi_byte_scheduler_if: byte request/acknowledge channel between one requester and the scheduler
//   req  : requester has a byte pending (held until ack)
//   data : byte to send, MSB first on the wire
//   dc   : D/C level for the byte (0 = command, 1 = data)
//   last : byte ends the requester's burst
//   ack  : one-cycle pulse when the byte has been shifted out
//   master = requester side, slave = scheduler side
interface spi_byte_scheduler_if;
    logic       req;
    logic [7:0] data;
    logic       dc;
    logic       last;
    logic       ack;
    modport master (output req, data, dc, last, input ack);
    modport slave  (input req, data, dc, last, output ack);
endinterface

// File: rtl/spi_byte_scheduler_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin arbiter with burst lock
//   i_req        : request vector, bit n = requester n
//   i_ptr        : most recent grantee; the other requester wins a tie
//   i_lock_valid : a burst lock is held
//   i_lock_owner : requester holding the lock
//   o_gnt_valid  : some requester is granted
//   o_gnt_idx    : index of the granted requester
module rr_arbiter2
    import spi_byte_scheduler_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    input  logic       i_lock_valid,
    input  logic       i_lock_owner,
    output logic       o_gnt_valid,
    output logic       o_gnt_idx
);
    logic w_lock_hit;

    // A lock whose owner has gone quiet is ignored, so normal arbitration applies in the same cycle
    assign w_lock_hit  = i_lock_valid && i_req[i_lock_owner];
    assign o_gnt_valid = |i_req;
    assign o_gnt_idx   = w_lock_hit ? i_lock_owner : (&i_req) ? ~i_ptr : i_req[REQ_R1];
endmodule

// File: rtl/spi_byte_scheduler.sv
// spi_byte_scheduler: arbitrates two byte requesters onto the single SPI byte engine
//   CLK, RST        : clock, synchronous active-high reset
//   r0, r1          : requester channels (0 = init/command path, 1 = frame/text refresh path)
//   o_spi_en        : start and hold an engine transfer
//   o_spi_data      : registered byte to the engine
//   i_spi_fin       : engine done state
//   o_dc            : registered D/C to the display pin
//   o_busy          : scheduler not idle
//   o_owner         : current or most recent grantee
//   o_timeout_err   : sticky engine-timeout flag
module spi_byte_scheduler
    import spi_byte_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    spi_byte_scheduler_if.slave  r0,
    spi_byte_scheduler_if.slave  r1,
    output logic                 o_spi_en,
    output logic [7:0]           o_spi_data,
    input  logic                 i_spi_fin,
    output logic                 o_dc,
    output logic                 o_busy,
    output logic                 o_owner,
    output logic                 o_timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic [7:0]    r_spi_data;
    logic          r_dc;
    logic          r_last;
    logic          r_owner;
    logic          r_lock_valid;
    logic          r_lock_owner;
    logic          r_timeout_err;
    logic [1:0]    w_req;
    logic [1:0]    w_ack;
    logic          w_gnt_valid;
    logic          w_gnt_idx;
    logic          w_grant;
    logic          w_fin_ack;
    logic          w_timeout;

    assign w_req     = {r1.req, r0.req};
    assign w_grant   = (r_state == IDLE) && w_gnt_valid;
    assign w_fin_ack = (r_state == WAIT_FIN) && i_spi_fin;
    assign w_cnt_inc = r_cnt + 1'b1;
    // Fires on the TIMEOUT_CYCLES-th WAIT_FIN cycle; a FIN in that same cycle still wins
    assign w_timeout = (r_state == WAIT_FIN) && !i_spi_fin && (w_cnt_inc == CW'(TIMEOUT_CYCLES));

    rr_arbiter2 u_arb (
        .i_req        (w_req),
        .i_ptr        (r_owner),
        .i_lock_valid (r_lock_valid),
        .i_lock_owner (r_lock_owner),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_idx    (w_gnt_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_gnt_valid ? LOAD : IDLE;
            LOAD:     w_next = WAIT_FIN;
            WAIT_FIN: w_next = (i_spi_fin || w_timeout) ? RELEASE : WAIT_FIN;
            RELEASE:  w_next = i_spi_fin ? RELEASE : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        o_spi_en = (r_state == LOAD) || (r_state == WAIT_FIN);
        o_busy   = r_state != IDLE;
        w_ack    = w_fin_ack ? ((r_owner == REQ_R1) ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_spi_data    <= 8'h00;
            r_dc          <= 1'b0;
            r_last        <= 1'b0;
            r_owner       <= REQ_R1;
            r_lock_valid  <= 1'b0;
            r_lock_owner  <= REQ_R0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            if (w_grant) begin
                r_owner    <= w_gnt_idx;
                r_spi_data <= w_gnt_idx ? r1.data : r0.data;
                r_dc       <= w_gnt_idx ? r1.dc : r0.dc;
                r_last     <= w_gnt_idx ? r1.last : r0.last;
            end
            r_cnt <= (r_state == WAIT_FIN) ? w_cnt_inc : '0;
            if (w_timeout) r_timeout_err <= 1'b1;
            if ((r_state == IDLE) && r_lock_valid && !w_req[r_lock_owner]) r_lock_valid <= 1'b0;
            if (w_fin_ack) begin
                r_lock_valid <= !r_last;
                r_lock_owner <= r_owner;
            end else if (w_timeout) begin
                r_lock_valid <= 1'b0;
            end
        end
    end

    assign r0.ack        = w_ack[0];
    assign r1.ack        = w_ack[1];
    assign o_spi_data    = r_spi_data;
    assign o_dc          = r_dc;
    assign o_owner       = r_owner;
    assign o_timeout_err = r_timeout_err;
endmodule

// File: tb/tb_spi_byte_scheduler.sv
// tb_spi_byte_scheduler: directed scoreboard bench for spi_byte_scheduler with a behavioural byte engine
//   Drives both requester channels, models the engine FIN handshake, compares ACK order and byte contents.
module tb_spi_byte_scheduler;
    localparam int LAT = 8;

    typedef logic [10:0] ent_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       spi_en;
    logic [7:0] spi_data;
    logic       fin = 1'b0;
    logic       dc;
    logic       busy;
    logic       owner;
    logic       terr;
    bit         fin_block = 1'b0;
    int         eng_cnt = 0;
    int         tail = 0;
    int         checks = 0;
    int         errors = 0;
    int         ack_cnt0 = 0;
    int         ack_cnt1 = 0;
    int         both_cnt = 0;
    int         a0;
    int         n;
    logic       prev_en = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_dc = 1'b0;
    ent_t       exp_q[$];
    ent_t       got_q[$];

    spi_byte_scheduler_if r0_if ();
    spi_byte_scheduler_if r1_if ();

    spi_byte_scheduler #(.TIMEOUT_CYCLES(400)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .r0            (r0_if),
        .r1            (r1_if),
        .o_spi_en      (spi_en),
        .o_spi_data    (spi_data),
        .i_spi_fin     (fin),
        .o_dc          (dc),
        .o_busy        (busy),
        .o_owner       (owner),
        .o_timeout_err (terr)
    );

    always #5 CLK = ~CLK;

    // Byte engine: FIN rises LAT cycles into a transfer and lingers a few cycles after EN drops
    always @(posedge CLK) begin
        if (spi_en && !fin_block) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == LAT) begin
                fin  <= 1'b1;
                tail <= 2;
            end
        end else if (!spi_en) begin
            eng_cnt <= 0;
            if (fin && tail == 0) fin <= 1'b0;
            else if (fin) tail <= tail - 1;
        end
    end

    always @(negedge CLK) begin
        if (spi_en && !prev_en) begin
            cap_data <= spi_data;
            cap_dc   <= dc;
        end
        prev_en <= spi_en;
        if (r0_if.ack) ack_cnt0 <= ack_cnt0 + 1;
        if (r1_if.ack) ack_cnt1 <= ack_cnt1 + 1;
        if (r0_if.ack && r1_if.ack) both_cnt <= both_cnt + 1;
        if (r0_if.ack || r1_if.ack)
            got_q.push_back({r1_if.ack, spi_data, dc, (spi_data === cap_data) && (dc === cap_dc)});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit idx, input logic req, input logic [7:0] data, input logic d, input logic last);
        if (idx) begin
            r1_if.req = req; r1_if.data = data; r1_if.dc = d; r1_if.last = last;
        end else begin
            r0_if.req = req; r0_if.data = data; r0_if.dc = d; r0_if.last = last;
        end
    endtask

    task automatic push(input bit idx, input logic [7:0] data, input logic d);
        exp_q.push_back({idx, data, d, 1'b1});
    endtask

    task automatic wait_ack(input bit idx, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if ((idx ? r1_if.ack : r0_if.ack) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " ack_seen"}, ok, 1);
        check({tag, " en_at_ack"}, spi_en, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " idle"}, ok, 1);
    endtask

    task automatic sb_check(input string tag);
        ent_t e;
        ent_t g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " sb_avail"}, got_q.size() > 0, 1);
            g = '0;
            if (got_q.size() > 0) g = got_q.pop_front();
            check({tag, " sb_entry"}, g, e);
        end
        check({tag, " sb_extra"}, got_q.size(), 0);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 0, 8'h00, 0, 0);
        drive(1, 0, 8'h00, 0, 0);
        repeat (3) @(negedge CLK);
        check("rst spi_en", spi_en, 0);
        check("rst spi_data", spi_data, 8'h00);
        check("rst dc", dc, 0);
        check("rst busy", busy, 0);
        check("rst owner", owner, 1);
        check("rst terr", terr, 0);
        check("rst acks", {r1_if.ack, r0_if.ack}, 2'b00);
        RST = 1'b0;
        @(negedge CLK);

        a0 = ack_cnt0;
        drive(0, 1, 8'hAE, 0, 1);
        push(0, 8'hAE, 0);
        check("t1 en_pre", spi_en, 0);
        @(negedge CLK);
        check("t1 en_load", spi_en, 1);
        check("t1 data", spi_data, 8'hAE);
        check("t1 dc", dc, 0);
        check("t1 owner", owner, 0);
        check("t1 busy", busy, 1);
        wait_ack(0, "t1");
        drive(0, 0, 8'hAE, 0, 1);
        @(negedge CLK);
        check("t1 en_drop", spi_en, 0);
        check("t1 ack_pulse", r0_if.ack, 0);
        wait_idle("t1");
        check("t1 fin_at_idle", fin, 0);
        check("t1 ack_count", ack_cnt0 - a0, 1);
        sb_check("t1");

        pulse_reset();
        drive(0, 1, 8'h81, 0, 1);
        drive(1, 1, 8'h55, 1, 1);
        push(0, 8'h81, 0);
        push(1, 8'h55, 1);
        @(negedge CLK);
        check("t2 owner0", owner, 0);
        wait_ack(0, "t2 r0");
        drive(0, 0, 8'h81, 0, 1);
        wait_ack(1, "t2 r1");
        check("t2 owner1", owner, 1);
        drive(1, 0, 8'h55, 1, 1);
        wait_idle("t2");
        sb_check("t2");

        drive(1, 1, 8'hA1, 1, 0);
        push(1, 8'hA1, 1);
        @(negedge CLK);
        drive(0, 1, 8'h10, 0, 1);
        wait_ack(1, "t3 b1");
        drive(1, 1, 8'hA2, 1, 0);
        push(1, 8'hA2, 1);
        wait_ack(1, "t3 b2");
        drive(1, 1, 8'hA3, 1, 1);
        push(1, 8'hA3, 1);
        wait_ack(1, "t3 b3");
        drive(1, 0, 8'hA3, 1, 1);
        push(0, 8'h10, 0);
        wait_ack(0, "t3 r0");
        drive(0, 0, 8'h10, 0, 1);
        wait_idle("t3");
        sb_check("t3");

        pulse_reset();
        drive(0, 1, 8'h22, 1, 0);
        drive(1, 1, 8'h33, 0, 1);
        push(0, 8'h22, 1);
        push(1, 8'h33, 0);
        wait_ack(0, "t4 r0");
        drive(0, 0, 8'h22, 1, 0);
        wait_idle("t4 gap");
        @(negedge CLK);
        check("t4 owner", owner, 1);
        check("t4 en", spi_en, 1);
        wait_ack(1, "t4 r1");
        drive(1, 0, 8'h33, 0, 1);
        wait_idle("t4");
        sb_check("t4");

        fin_block = 1'b1;
        a0 = ack_cnt0;
        drive(0, 1, 8'h5A, 0, 1);
        @(negedge CLK);
        n = 0;
        while (spi_en === 1'b1 && n < 1000) begin
            n++;
            @(negedge CLK);
        end
        check("t5 en_cycles", n, 401);
        check("t5 terr", terr, 1);
        check("t5 no_ack", ack_cnt0 - a0, 0);
        fin_block = 1'b0;
        push(0, 8'h5A, 0);
        wait_ack(0, "t5 retry");
        drive(0, 0, 8'h5A, 0, 1);
        wait_idle("t5");
        check("t5 terr_sticky", terr, 1);
        sb_check("t5");

        a0 = ack_cnt0;
        drive(0, 1, 8'h77, 1, 1);
        @(negedge CLK);
        repeat (3) @(negedge CLK);
        check("t6 en_wait", spi_en, 1);
        RST = 1'b1;
        drive(0, 0, 8'h77, 1, 1);
        @(negedge CLK);
        check("t6 en", spi_en, 0);
        check("t6 owner", owner, 1);
        check("t6 terr", terr, 0);
        check("t6 busy", busy, 0);
        RST = 1'b0;
        check("t6 no_ack", ack_cnt0 - a0, 0);
        drive(1, 1, 8'h3C, 1, 1);
        push(1, 8'h3C, 1);
        wait_ack(1, "t6 r1");
        drive(1, 0, 8'h3C, 1, 1);
        wait_idle("t6");
        sb_check("t6");

        check("ack_overlap", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
